// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the RV32IM instruction-fetch stage:
//   - if_state_t   : fetch FSM state encoding (RST_WAIT=0, FETCH=1, KILL=2)
//   - IF_NOP_INSTR : canonical bubble instruction, addi x0,x0,0
//   - IF_RESET_PC  : default program counter after reset
//   - if_id_t      : IF/ID pipeline register payload (97 bits)
//   - word_align() : clears the two low address bits of a fetch target
// ---------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        KILL     = 2'd2
    } if_state_t;

    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // Instructions are word aligned; the low two bits of any target are
    // dropped rather than trapped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : if_pkg

// File: rtl/if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register
// IF/ID pipeline register (97 bits). Flush has priority over load; with
// neither asserted the register holds.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_load            : capture a fetched instruction
//   i_flush           : replace the held instruction with a NOP bubble
//   i_pc, i_pc_plus4  : PC of the fetched instruction and PC+4
//   i_instr           : fetched instruction word
//   o_pc, o_pc_plus4, o_instr, o_valid : registered IF/ID contents
// ---------------------------------------------------------------------------
module if_id_register
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    if_id_t r_if_id;

    // NOTE: sequential state is written with non-blocking assignments only so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id <= '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else if (i_flush) begin
            // The PC fields are left as they were; with valid low they are
            // don't-care for decode.
            r_if_id.instr <= NOP_INSTR;
            r_if_id.valid <= 1'b0;
        end else if (i_load) begin
            r_if_id <= '{pc: i_pc, pc_plus4: i_pc_plus4, instr: i_instr, valid: 1'b1};
        end
    end

    assign o_pc       = r_if_id.pc;
    assign o_pc_plus4 = r_if_id.pc_plus4;
    assign o_instr    = r_if_id.instr;
    assign o_valid    = r_if_id.valid;

endmodule : if_id_register

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage of the RV32IM pipeline: program counter, instruction-cache fetch
// with busywait handshake, redirect handling and the IF/ID register.
// Ports:
//   CLK, RESET        : clock, asynchronous active-low reset
//   NEXT_PC           : next-PC mux output (PC_PLUS4 or branch target)
//   BRANCH_TAKEN      : redirect/flush request from EX
//   STALL             : hazard-unit stall, holds PC and IF/ID
//   IMEM_INSTR        : instruction-cache read data
//   IMEM_BUSYWAIT     : instruction-cache miss in progress
//   IMEM_ADDR         : fetch address (always the PC)
//   IMEM_READ         : fetch request
//   PC_PLUS4          : combinational PC+4, to next-PC mux IN0
//   IF_PC, IF_PC_PLUS4, IF_INSTR, IF_VALID : IF/ID register outputs
//   FETCH_STALL       : cache busy, freeze downstream stages
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] NEXT_PC,
    input  logic        BRANCH_TAKEN,
    input  logic        STALL,
    input  logic [31:0] IMEM_INSTR,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC_PLUS4,
    output logic [31:0] IF_INSTR,
    output logic        IF_VALID,
    output logic        FETCH_STALL
);

    if_state_t   r_state;
    if_state_t   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_redirect_pc;
    logic [31:0] w_redirect_next;
    logic        w_load;
    logic        w_flush;
    logic [31:0] w_target;

    assign w_target = word_align(NEXT_PC);

    // -----------------------------------------------------------------------
    // State, PC and pending-redirect registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= RST_WAIT;
            r_pc          <= RESET_PC;
            r_redirect_pc <= 32'h0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_redirect_pc <= w_redirect_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_redirect_next = r_redirect_pc;
        w_load          = 1'b0;
        w_flush         = 1'b0;

        unique case (r_state)
            RST_WAIT: begin
                w_state_next = FETCH;
            end

            FETCH: begin
                if (BRANCH_TAKEN && !IMEM_BUSYWAIT) begin
                    // Redirect on a hit: the fetched word is on the wrong
                    // path, so IF/ID takes a bubble. Flush beats STALL.
                    w_pc_next = w_target;
                    w_flush   = 1'b1;
                end else if (BRANCH_TAKEN) begin
                    // The cache cannot abort a miss: park the target and keep
                    // the address stable until the miss completes.
                    w_redirect_next = w_target;
                    w_flush         = 1'b1;
                    w_state_next    = KILL;
                end else if (!IMEM_BUSYWAIT && !STALL) begin
                    w_load    = 1'b1;
                    w_pc_next = w_target;
                end
            end

            KILL: begin
                // EX is bubbled here, so BRANCH_TAKEN cannot legitimately
                // fire and is ignored. The late cache data is dropped.
                if (!IMEM_BUSYWAIT) begin
                    w_pc_next    = r_redirect_pc;
                    w_state_next = FETCH;
                end
            end

            default: begin
                w_state_next = RST_WAIT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Combinational outputs
    // -----------------------------------------------------------------------
    assign IMEM_ADDR   = r_pc;
    assign IMEM_READ   = (r_state != RST_WAIT);
    assign PC_PLUS4    = r_pc + 32'd4;  // wraps modulo 2^32
    assign FETCH_STALL = IMEM_READ & IMEM_BUSYWAIT;

    // -----------------------------------------------------------------------
    // IF/ID pipeline register
    // -----------------------------------------------------------------------
    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (CLK),
        .rst_n      (RESET),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_pc       (r_pc),
        .i_pc_plus4 (PC_PLUS4),
        .i_instr    (IMEM_INSTR),
        .o_pc       (IF_PC),
        .o_pc_plus4 (IF_PC_PLUS4),
        .o_instr    (IF_INSTR),
        .o_valid    (IF_VALID)
    );

endmodule : instruction_fetch_unit
